// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI mode-0 slave receiver.
// Holds the FSM state enum, the status-byte layout and the FIFO entry width.
package spi_rx_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // FIFO entry: {first_flag, data[7:0]}
    localparam int ENTRY_W      = 9;

    // Status byte: {overflow, 2'b00, count[4:0] saturated}
    localparam int STAT_OVF_BIT = 7;
    localparam int STAT_CNT_W   = 5;
    localparam int STAT_CNT_MAX = 31;

    function automatic logic [7:0] status_byte(input logic ovf,
                                               input int unsigned cnt);
        logic [7:0] s;
        s = '0;
        s[STAT_OVF_BIT] = ovf;
        if (cnt > STAT_CNT_MAX)
            s[STAT_CNT_W-1:0] = STAT_CNT_W'(STAT_CNT_MAX);
        else
            s[STAT_CNT_W-1:0] = STAT_CNT_W'(cnt);
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with a registered head output.
// Head register looks at pre-push occupancy, so a write shows one edge later.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 4");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d, avail;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && valid_q;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Next head: entries that existed before this edge's write
    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        avail    = count_q - CW'(pop_ok);
        valid_d  = (avail != '0);
        dout_d   = valid_d ? mem_q[rd_ptr_d] : '0;
    end

    // Storage array, written without reset
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    assign rdata_o = dout_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: synchronizes SCK/SS/MOSI into SYSCLK, shifts
// bytes into a FIFO tagged with a first-of-frame flag, returns status on MISO.
module spi_slave_rx
    import spi_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SCK_DIV_MIN = 8
) (
    input  logic                          SYSCLK,
    input  logic                          SYSRESET,
    input  logic                          SPI_CLK,
    input  logic                          SPI_SS,
    input  logic                          SPI_MOSI,
    output logic                          SPI_MISO,
    output logic [7:0]                    DOUT,
    output logic                          DOUT_FIRST,
    output logic                          DOUT_VALID,
    input  logic                          DOUT_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVERFLOW,
    input  logic                          OVF_CLR
);

    if (SCK_DIV_MIN < 2) begin : g_bad_div
        $error("spi_slave_rx: SCK_DIV_MIN must be >= 2");
    end

    logic [2:0]         sck_q, ss_q;
    logic [1:0]         mosi_q;
    logic [1:0]         live_q;
    logic               armed_q;
    state_e             state_q;
    logic [2:0]         bit_cnt_q;
    logic               first_q;
    logic [6:0]         rx_q;
    logic [7:0]         tx_q, stat_q;
    logic               push_q;
    logic [ENTRY_W-1:0] push_data_q;
    logic               ovf_q;

    logic               sck_rise, sck_fall, ss_fall, ss_rise;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_valid, fifo_full, fifo_empty, pop, drop;
    logic [7:0]         status;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ss_fall  = ~ss_q[1] & ss_q[2];
    assign ss_rise  = ss_q[1] & ~ss_q[2];
    assign status   = status_byte(ovf_q, 32'(FIFO_COUNT));
    assign pop      = DOUT_READY & fifo_valid & ~fifo_empty;
    assign drop     = push_q & fifo_full & ~pop;

    // Two-flop synchronizers plus an edge-detect stage on SCK and SS
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            sck_q  <= 3'b000;
            ss_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], SPI_CLK};
            ss_q   <= {ss_q[1:0], SPI_SS};
            mosi_q <= {mosi_q[0], SPI_MOSI};
        end
    end

    // Receive FSM: frame control, rx/tx shifters and push request
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            live_q      <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            first_q     <= 1'b0;
            rx_q        <= '0;
            tx_q        <= '0;
            stat_q      <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= 1'b0;
            live_q <= {live_q[0], 1'b1};
            // SS must be seen high after reset before a fall counts
            if (live_q[1] && ss_q[1]) armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (ss_fall && armed_q) begin
                        state_q   <= ACTIVE;
                        bit_cnt_q <= 3'd0;
                        first_q   <= 1'b1;
                        stat_q    <= status;
                        tx_q      <= status;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= 3'd0;
                        tx_q      <= '0;
                    end else begin
                        if (sck_rise) begin
                            rx_q      <= {rx_q[5:0], mosi_q[1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                push_q      <= 1'b1;
                                push_data_q <= {first_q, rx_q, mosi_q[1]};
                                first_q     <= 1'b0;
                            end
                        end
                        if (sck_fall) begin
                            if (bit_cnt_q == 3'd0)
                                tx_q <= stat_q;
                            else
                                tx_q <= {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle beats a clear
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET)     ovf_q <= 1'b0;
        else if (drop)    ovf_q <= 1'b1;
        else if (OVF_CLR) ovf_q <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (SYSCLK),
        .rst_i   (SYSRESET),
        .push_i  (push_q),
        .wdata_i (push_data_q),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (FIFO_COUNT),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign SPI_MISO   = tx_q[7];
    assign DOUT       = fifo_rdata[7:0];
    assign DOUT_FIRST = fifo_rdata[ENTRY_W-1];
    assign DOUT_VALID = fifo_valid;
    assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed frames plus random frames against a
// queue-based reference of the receive FIFO, overflow flag and status byte.
module tb_spi_slave_rx;

    localparam int DEPTH = 16;
    localparam int HALF  = 5;

    logic       clk = 1'b0;
    logic       rst, sck, ss, mosi, ready, ovf_clr;
    logic       miso, dvalid, dfirst, ovf;
    logic [7:0] dout;
    logic [4:0] count;

    int n_tests, n_fail;

    logic [8:0] mq[$];
    logic       m_ovf;
    logic       m_first;

    always #5 clk = ~clk;

    spi_slave_rx #(
        .FIFO_DEPTH  (DEPTH),
        .SCK_DIV_MIN (8)
    ) dut (
        .SYSCLK     (clk),
        .SYSRESET   (rst),
        .SPI_CLK    (sck),
        .SPI_SS     (ss),
        .SPI_MOSI   (mosi),
        .SPI_MISO   (miso),
        .DOUT       (dout),
        .DOUT_FIRST (dfirst),
        .DOUT_VALID (dvalid),
        .DOUT_READY (ready),
        .FIFO_COUNT (count),
        .OVERFLOW   (ovf),
        .OVF_CLR    (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void m_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back({m_first, b});
        else m_ovf = 1'b1;
        m_first = 1'b0;
    endfunction

    function automatic logic [7:0] m_status();
        int c;
        c = (mq.size() > 31) ? 31 : mq.size();
        return 8'((m_ovf ? 128 : 0) + c);
    endfunction

    task automatic frame_begin();
        @(negedge clk);
        ss = 1'b0;
        m_first = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (12) @(negedge clk);
        check("miso_idle", miso, 0);
    endtask

    // mode 1: check head latency on the last bit; mode 2: pop on push edge
    task automatic spi_xfer(input logic [7:0] b, input int nbits,
                            input int mode, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = b[i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            rx[i] = miso;
            if (i == 0 && mode == 1) begin
                @(posedge clk);
                repeat (3) @(posedge clk);
                #1 check("lat_n3_valid", dvalid, 0);
                @(posedge clk);
                #1 check("lat_n4_valid", dvalid, 1);
                check("lat_n4_data", {dfirst, dout}, {1'b1, b});
                @(negedge clk);
            end else if (i == 0 && mode == 2) begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("fullpop_head", {dfirst, dout}, mq[0]);
                ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                ready = 1'b0;
                void'(mq.pop_front());
                repeat (2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sck = 1'b0;
        end
    endtask

    task automatic drain_check(input string tag);
        @(negedge clk);
        ready = 1'b1;
        while (mq.size() != 0) begin
            check({tag, "_valid"}, dvalid, 1);
            check({tag, "_data"}, {dfirst, dout}, mq[0]);
            void'(mq.pop_front());
            @(negedge clk);
        end
        ready = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_cnt"}, count, 0);
        check({tag, "_empty"}, dvalid, 0);
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        check("ovf_clr", ovf, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx, st, b;
        int nb;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; sck = 1'b0; ss = 1'b1; mosi = 1'b0;
        ready = 1'b0; ovf_clr = 1'b0;
        m_ovf = 1'b0; m_first = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_first", dfirst, 0);
        check("rst_valid", dvalid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", ovf, 0);
        check("rst_miso", miso, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single frame with latency check
        frame_begin();
        spi_xfer(8'hA5, 8, 1, rx);
        check("single_miso0", rx, m_status());
        m_push(8'hA5);
        spi_xfer(8'h3C, 8, 0, rx);
        m_push(8'h3C);
        frame_end();
        check("single_cnt", count, 2);
        drain_check("single");

        // runt byte then fresh frame
        frame_begin();
        spi_xfer(8'hFF, 5, 0, rx);
        frame_end();
        check("runt_cnt", count, 0);
        check("runt_ovf", ovf, 0);
        frame_begin();
        spi_xfer(8'h5A, 8, 0, rx);
        m_push(8'h5A);
        frame_end();
        drain_check("runt_next");

        // overflow with 17 bytes
        frame_begin();
        for (int i = 0; i <= 16; i++) begin
            spi_xfer(8'(i), 8, 0, rx);
            m_push(8'(i));
        end
        frame_end();
        check("ovf_cnt", count, 16);
        check("ovf_set", ovf, 1);
        drain_check("ovf_drain");
        check("ovf_sticky", ovf, 1);

        // status byte with 3 queued and overflow set
        frame_begin();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            spi_xfer(b, 8, 0, rx);
            m_push(b);
        end
        frame_end();
        frame_begin();
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            spi_xfer(b, 8, 0, rx);
            check("stat_0x83", rx, 8'h83);
            m_push(b);
        end
        frame_end();
        drain_check("stat_drain");
        clear_ovf();

        // full FIFO with pop on the push edge
        frame_begin();
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            spi_xfer(b, 8, 0, rx);
            m_push(b);
        end
        frame_end();
        check("full_cnt", count, 16);
        frame_begin();
        b = 8'($urandom);
        spi_xfer(b, 8, 2, rx);
        m_push(b);
        frame_end();
        check("fullpop_cnt", count, 16);
        check("fullpop_ovf", ovf, 0);
        drain_check("fullpop");

        // reset mid-frame, SS held low across release
        frame_begin();
        spi_xfer(8'h11, 8, 0, rx);
        m_push(8'h11);
        spi_xfer(8'hC3, 4, 0, rx);
        @(negedge clk);
        rst = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_dout", dout, 0);
        check("mrst_valid", dvalid, 0);
        check("mrst_count", count, 0);
        check("mrst_miso", miso, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        spi_xfer(8'h77, 8, 0, rx);
        repeat (10) @(negedge clk);
        check("mrst_nopush", count, 0);
        frame_end();
        frame_begin();
        spi_xfer(8'h3C, 8, 0, rx);
        m_push(8'h3C);
        frame_end();
        drain_check("mrst_next");

        // randomized frames
        for (int it = 0; it < 25; it++) begin
            frame_begin();
            st = m_status();
            nb = $urandom_range(1, 5);
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
                spi_xfer(b, 8, 0, rx);
                check("rnd_miso", rx, st);
                m_push(b);
            end
            if ($urandom_range(0, 3) == 0)
                spi_xfer(8'($urandom), $urandom_range(1, 7), 0, rx);
            frame_end();
            check("rnd_cnt", count, mq.size());
            check("rnd_ovf", ovf, m_ovf);
            if ($urandom_range(0, 2) == 0) begin
                drain_check("rnd_drain");
                clear_ovf();
            end
        end
        drain_check("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI mode-0 slave receiver in the fabric, directly downstream of the MSS SPI_0 master (SPI_0_CLK, SPI_0_SS, SPI_0_DO). It deserializes bytes sent by firmware and buffers them in a small FIFO for the fabric consumer, such as the LED frame engine. It tags the first byte of every SS frame and returns a status byte on MISO (SPI_0_DI).

## Interface
- FIFO_DEPTH, 16: FIFO entries; power of two, minimum 4.
- SCK_DIV_MIN, 8: documented minimum SYSCLK/SPI_CLK ratio. Used only for bench checking; no logic.
- SYSCLK  in  1  fabric clock. All logic is in this single domain.
- SYSRESET  in  1  asynchronous, active-high reset.
- SPI_CLK  in  1  SCK from MSS; asynchronous to SYSCLK.
- SPI_SS  in  1  slave select, active low.
- SPI_MOSI  in  1  data from MSS (SPI_0_DO).
- SPI_MISO  out  1  data to MSS (SPI_0_DI).
- DOUT  out  8  head-of-FIFO byte.
- DOUT_FIRST  out  1  head byte was the first byte after an SS fall.
- DOUT_VALID  out  1  head entry present.
- DOUT_READY  in  1  consumer accept; pop when VALID && READY.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  occupancy.
- OVERFLOW  out  1  sticky; a completed byte was dropped.
- OVF_CLR  in  1  single-cycle clear of OVERFLOW.

## Operation
- **Synchronizers:** SPI_CLK, SPI_SS and SPI_MOSI each pass through 2 flops, plus a third flop on SPI_CLK and SPI_SS for edge detection. All protocol logic uses the synchronized signals only.
- **States:**
  - IDLE:
    - Stays in IDLE while synchronized SS is high.
    - SS fall → ACTIVE.
    - On the SS fall: bit_cnt=0, first_flag=1, and status byte {OVERFLOW, 2'b00, FIFO_COUNT[4:0] saturated at 31} is loaded into the tx shifter.
  - ACTIVE:
    - SCK rise: shift MOSI into rx shifter MSB-first; bit_cnt++.
    - When bit_cnt wraps 7→0, push {first_flag, byte} and clear first_flag.
    - SCK fall: tx shifter shifts left and SPI_MISO takes the new MSB.
    - SS rise → IDLE. A partial byte (bit_cnt≠0) is discarded silently.
- **MISO:**
  - Drives tx shifter MSB while ACTIVE; drives 0 in IDLE.
  - The status byte repeats for every byte of the frame: the shifter reloads on each byte boundary.
- **FIFO:**
  - Push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle (count unchanged).
  - Otherwise the byte is dropped and OVERFLOW=1.
  - Pop on empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- **OVERFLOW:**
  - Sets on a dropped byte.
  - Clears on OVF_CLR.
  - If a set and OVF_CLR occur in the same cycle, set wins.
- **Reset:**
  - Asserting SYSRESET mid-frame returns the block to IDLE and empties the FIFO.
  - After release, the block resumes only on the next SS fall, even if SS is already low.

## Timing
- **Reset values:** DOUT=0x00, DOUT_FIRST=0, DOUT_VALID=0, FIFO_COUNT=0, OVERFLOW=0, SPI_MISO=0. All synchronizer flops reset as SCK=0 and SS=1.
- **Push latency:** when the first sync flop captures the 8th SCK rise at edge N, the push occurs at edge N+3. With the FIFO previously empty, DOUT/DOUT_VALID are valid after edge N+4.
- **Show-ahead:** DOUT is registered. After a pop, the next entry appears on the following edge with no bubble when count≥2.
- **MISO setup:** MISO updates 3 SYSCLK after the SCK fall. This is valid for mode 0 when SYSCLK/SPI_CLK ≥ SCK_DIV_MIN.
- **SS to first SCK rise:** requires ≥4 SYSCLK.

## Structure
- **Package spi_rx_pkg:** state enum (IDLE, ACTIVE), status-byte field positions, and the FIFO entry width constant (9).
- **Sub-module sync_fifo:** parameterized width/depth, show-ahead, with count and full/empty outputs. The receive FSM and shifters stay in spi_slave_rx.

## Test plan
- **Single frame:** SS low, send 0xA5, 0x3C at SYSCLK/10, SS high → two entries: (0xA5, FIRST=1) then (0x3C, FIRST=0). DOUT_VALID rises exactly 4 SYSCLK after the sync capture of the 8th SCK rise.
- **Runt byte:** SS high after 5 bits of 0xFF → FIFO_COUNT stays 0, no OVERFLOW. The next frame's first byte has FIRST=1.
- **Overflow:** DOUT_READY=0, send 17 bytes 0x00..0x10 → FIFO_COUNT=16 and OVERFLOW=1. Draining yields 0x00..0x0F; 0x10 is lost. OVF_CLR then clears OVERFLOW.
- **Full + simultaneous pop:** hold the FIFO at 16 and pulse DOUT_READY on the push cycle → byte accepted, count stays 16, OVERFLOW stays 0.
- **MISO status:** with 3 entries queued and OVERFLOW=1, start a frame → master reads 0x83 on each byte.
- **Reset mid-frame:** SYSRESET asserted after 4 bits → all outputs at reset values. SS is held low after release → no push until SS rises and falls again.
